// File: rtl/synth_pkg.sv
// Shared sequencer defaults and state encoding.
// Imported by note_sequencer and seq_step_timer.
package synth_pkg;

  localparam int FREQ_W_DEF = 32;
  localparam int NSTEPS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REC,
    ST_PLAY_ON,
    ST_PLAY_GAP
  } seq_state_t;

endpackage

// File: rtl/seq_step_timer.sv
// Step tick counter with end-of-step and gate-gap strobes.
// Swing timing enabled by NOTE_SEQUENCER_SWING_EN.
module seq_step_timer
  import synth_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int GAP_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_tick,
  input  logic             i_odd,
  input  logic [LEN_W-1:0] i_step_len,
  output logic             o_step_end,
  output logic             o_gap_start
);

  localparam logic [LEN_W:0] GAP  = (LEN_W+1)'(GAP_TICKS);
  localparam logic [LEN_W:0] LMAX = {1'b0, {LEN_W{1'b1}}};

  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W:0]   w_base;
  logic [LEN_W:0]   w_len;
  logic [LEN_W:0]   w_cnt1;

  assign w_base = (i_step_len == '0) ? (LEN_W+1)'(1)
                                     : {1'b0, i_step_len};

`ifdef NOTE_SEQUENCER_SWING_EN
  logic [LEN_W:0] w_q;
  logic [LEN_W:0] w_sum;
  logic [LEN_W:0] w_long;
  logic [LEN_W:0] w_short;

  // base >= 1 and q <= base/4, so the short step never drops below 1
  assign w_q     = w_base >> 2;
  assign w_sum   = w_base + w_q;
  assign w_long  = (w_sum > LMAX) ? LMAX : w_sum;
  assign w_short = w_base - w_q;
  assign w_len   = i_odd ? w_long : w_short;
`else
  logic w_unused;

  assign w_unused = i_odd;
  assign w_len    = w_base;
`endif

  assign w_cnt1 = {1'b0, r_cnt} + (LEN_W+1)'(1);

  // cnt >= len-1 written as cnt+1 >= len to avoid underflow
  assign o_step_end = i_en && i_tick && (w_cnt1 >= w_len);

  assign o_gap_start = i_en && i_tick && !o_step_end &&
                       (w_len > GAP) &&
                       (w_cnt1 >= (w_len - GAP));

  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= o_step_end ? '0 : w_cnt1[LEN_W-1:0];
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Step sequencer: keypad passthrough, pattern record, pattern play.
// Optional swing timing: define NOTE_SEQUENCER_SWING_EN.
module note_sequencer
  import synth_pkg::*;
#(
  parameter int NSTEPS    = NSTEPS_DEF,
  parameter int FREQ_W    = FREQ_W_DEF,
  parameter int LEN_W     = 16,
  parameter int GAP_TICKS = 4,
  localparam int IW = (NSTEPS > 1) ? $clog2(NSTEPS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [FREQ_W-1:0] key_freq,
  input  logic              run,
  input  logic              rec,
  input  logic [LEN_W-1:0]  step_len,
  output logic [FREQ_W-1:0] freq,
  output logic              gate,
  output logic [IW-1:0]     step_idx
);

  seq_state_t r_state;
  seq_state_t w_nxt_state;

  logic [FREQ_W-1:0] r_pat [NSTEPS];
  logic [FREQ_W-1:0] r_freq;
  logic [FREQ_W-1:0] w_nxt_freq;
  logic [FREQ_W-1:0] w_pat0;
  logic [FREQ_W-1:0] w_pat_nx;
  logic [IW-1:0]     r_idx;
  logic [IW-1:0]     w_nxt_idx;
  logic [IW-1:0]     w_idx_inc;
  logic              r_gate;
  logic              w_nxt_gate;
  logic              r_key_nz;
  logic              w_key_nz;
  logic              w_we;
  logic              w_play;
  logic              w_stay;
  logic              w_step_end;
  logic              w_gap_start;

  assign w_key_nz  = (key_freq != '0);
  assign w_idx_inc = r_idx + IW'(1);
  assign w_pat0    = r_pat[0];
  assign w_pat_nx  = r_pat[w_idx_inc];
  assign w_play    = (r_state == ST_PLAY_ON) ||
                     (r_state == ST_PLAY_GAP);
  // counter only runs while play continues; mode changes drop the tick
  assign w_stay    = w_play && run && !rec;

  seq_step_timer #(
    .LEN_W     (LEN_W),
    .GAP_TICKS (GAP_TICKS)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .i_en        (w_stay),
    .i_tick      (tick),
    .i_odd       (r_idx[0]),
    .i_step_len  (step_len),
    .o_step_end  (w_step_end),
    .o_gap_start (w_gap_start)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_freq  = r_freq;
    w_nxt_gate  = r_gate;
    w_we        = 1'b0;
    if (rec) begin
      w_nxt_state = ST_REC;
      w_nxt_freq  = key_freq;
      w_nxt_gate  = w_key_nz;
      if (r_state == ST_REC && w_key_nz && !r_key_nz) begin
        w_we      = 1'b1;
        w_nxt_idx = w_idx_inc;
      end
    end else begin
      unique case (r_state)
        ST_IDLE, ST_REC: begin
          w_nxt_idx = '0;
          if (run) begin
            w_nxt_state = ST_PLAY_ON;
            w_nxt_freq  = w_pat0;
            w_nxt_gate  = (w_pat0 != '0);
          end else begin
            w_nxt_state = ST_IDLE;
            w_nxt_freq  = key_freq;
            w_nxt_gate  = w_key_nz;
          end
        end
        ST_PLAY_ON, ST_PLAY_GAP: begin
          if (!run) begin
            w_nxt_state = ST_IDLE;
            w_nxt_idx   = '0;
            w_nxt_freq  = key_freq;
            w_nxt_gate  = w_key_nz;
          end else if (w_step_end) begin
            w_nxt_state = ST_PLAY_ON;
            w_nxt_idx   = w_idx_inc;
            w_nxt_freq  = w_pat_nx;
            w_nxt_gate  = (w_pat_nx != '0);
          end else if (r_state == ST_PLAY_ON &&
                       w_gap_start) begin
            w_nxt_state = ST_PLAY_GAP;
            w_nxt_gate  = 1'b0;
          end
        end
        default: w_nxt_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_freq   <= '0;
      r_gate   <= 1'b0;
      r_idx    <= '0;
      r_key_nz <= 1'b0;
      for (int i = 0; i < NSTEPS; i++) begin
        r_pat[i] <= '0;
      end
    end else begin
      r_state  <= w_nxt_state;
      r_freq   <= w_nxt_freq;
      r_gate   <= w_nxt_gate;
      r_idx    <= w_nxt_idx;
      r_key_nz <= w_key_nz;
      if (w_we) begin
        r_pat[r_idx] <= key_freq;
      end
    end
  end

  assign freq     = r_freq;
  assign gate     = r_gate;
  assign step_idx = r_idx;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed scoreboard bench for note_sequencer.
// Expected outputs queued at drive time, checked after each edge.
module tb_note_sequencer;
  import synth_pkg::*;

  localparam int FW  = 32;
  localparam int LW  = 16;
  localparam int NS  = 8;
  localparam int GAP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic          run;
  logic          rec;
  logic [FW-1:0] key_freq;
  logic [LW-1:0] step_len;
  logic [FW-1:0] freq;
  logic          gate;
  logic [2:0]    step_idx;

  typedef struct {
    logic [FW-1:0] f;
    logic          g;
    logic [2:0]    i;
  } exp_t;

  exp_t          sb [$];
  int            n_chk = 0;
  int            n_err = 0;
  logic [FW-1:0] pat [NS];
  int            m_idx;
  int            m_cnt;
  bit            m_gap;
  int            hi_cnt;

  note_sequencer #(
    .NSTEPS    (NS),
    .FREQ_W    (FW),
    .LEN_W     (LW),
    .GAP_TICKS (GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .key_freq (key_freq),
    .run      (run),
    .rec      (rec),
    .step_len (step_len),
    .freq     (freq),
    .gate     (gate),
    .step_idx (step_idx)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [FW-1:0] f,
                      input logic g,
                      input logic [2:0] i);
    exp_t e;
    e.f = f;
    e.g = g;
    e.i = i;
    sb.push_back(e);
  endtask

  task automatic cyc_chk(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      n_chk++;
      assert (freq === e.f) else begin
        n_err++;
        $error("FAIL %s freq got=%0d exp=%0d",
               tag, freq, e.f);
      end
      n_chk++;
      assert (gate === e.g) else begin
        n_err++;
        $error("FAIL %s gate got=%0b exp=%0b",
               tag, gate, e.g);
      end
      n_chk++;
      assert (step_idx === e.i) else begin
        n_err++;
        $error("FAIL %s idx got=%0d exp=%0d",
               tag, step_idx, e.i);
      end
    end
  endtask

  function automatic int elen(input int sl, input int idx);
    int l;
    l = (sl == 0) ? 1 : sl;
`ifdef NOTE_SEQUENCER_SWING_EN
    if (idx % 2 == 1) begin
      l = l + l / 4;
      if (l > 65535) l = 65535;
    end else begin
      l = l - l / 4;
    end
`else
    if (idx < 0) l = 1;
`endif
    return l;
  endfunction

  task automatic play_start(input string tag);
    m_idx = 0;
    m_cnt = 0;
    m_gap = 0;
    push(pat[0], pat[0] != 0, 3'd0);
    cyc_chk(tag);
  endtask

  task automatic play_cyc(input string tag);
    int l;
    if (tick) begin
      l = elen(int'(step_len), m_idx);
      if (m_cnt >= l - 1) begin
        m_idx = (m_idx + 1) % NS;
        m_cnt = 0;
        m_gap = 0;
      end else begin
        m_cnt++;
        if (l > GAP && m_cnt >= l - GAP) m_gap = 1;
      end
    end
    push(pat[m_idx], !m_gap && (pat[m_idx] != 0),
         m_idx[2:0]);
    cyc_chk(tag);
  endtask

  initial begin
    for (int i = 0; i < NS; i++) pat[i] = '0;
    rst      = 1'b1;
    run      = 1'b1;
    rec      = 1'b0;
    tick     = 1'b1;
    key_freq = 32'd1000;
    step_len = 16'd10;

    push(0, 0, 0); cyc_chk("rst1");
    push(0, 0, 0); cyc_chk("rst2");

    rst = 1'b0; run = 1'b0; key_freq = 32'd300;
    push(300, 1, 0); cyc_chk("idle_pass");
    key_freq = 0;
    push(0, 0, 0); cyc_chk("idle_zero");

    rec = 1'b1;
    push(0, 0, 0); cyc_chk("rec_enter");
    key_freq = 32'd440;
    push(440, 1, 1); cyc_chk("rec_w0");
    push(440, 1, 1); cyc_chk("rec_hold_a");
    push(440, 1, 1); cyc_chk("rec_hold_b");
    key_freq = 0;
    push(0, 0, 1); cyc_chk("rec_rel0");
    key_freq = 32'd494;
    push(494, 1, 2); cyc_chk("rec_w1");
    key_freq = 0;
    push(0, 0, 2); cyc_chk("rec_rel1");
    key_freq = 32'd523;
    push(523, 1, 3); cyc_chk("rec_w2");
    key_freq = 0;
    push(0, 0, 3); cyc_chk("rec_rel2");
    pat[0] = 32'd440;
    pat[1] = 32'd494;
    pat[2] = 32'd523;
    rec = 1'b0;
    push(0, 0, 0); cyc_chk("rec_exit");

    run = 1'b1; step_len = 16'd10; tick = 1'b1;
    play_start("play10");
    hi_cnt = gate ? 1 : 0;
    for (int c = 1; c < 93; c++) begin
      play_cyc("play10");
      if (c < 10 && gate) hi_cnt++;
    end
    n_chk++;
`ifdef NOTE_SEQUENCER_SWING_EN
    assert (hi_cnt === 4) else begin
`else
    assert (hi_cnt === 6) else begin
`endif
      n_err++;
      $error("FAIL gate_hi_step0 got=%0d", hi_cnt);
    end
    run = 1'b0;
    push(0, 0, 0); cyc_chk("run_drop");

    run = 1'b1; step_len = 16'd0;
    play_start("len0");
    for (int c = 1; c < 11; c++) play_cyc("len0");
    run = 1'b0;
    push(0, 0, 0); cyc_chk("len0_stop");

    run = 1'b1; step_len = 16'd3;
    play_start("len3");
    for (int c = 1; c < 13; c++) play_cyc("len3");
    run = 1'b0;
    push(0, 0, 0); cyc_chk("len3_stop");

    run = 1'b1; step_len = 16'd2; tick = 1'b0;
    play_start("sparse");
    for (int c = 1; c < 13; c++) begin
      tick = (c % 2 == 1);
      play_cyc("sparse");
    end
    run = 1'b0; tick = 1'b1;
    push(0, 0, 0); cyc_chk("sparse_stop");

    run = 1'b1; step_len = 16'd10;
    play_start("pre_rec");
    play_cyc("pre_rec");
    play_cyc("pre_rec");
    rec = 1'b1; key_freq = 32'd700;
    push(700, 1, 0); cyc_chk("rec_mid_play");
    push(700, 1, 0); cyc_chk("rec_held_key");
    rec = 1'b0; run = 1'b0;
    push(700, 1, 0); cyc_chk("rec_to_idle");
    key_freq = 0;
    push(0, 0, 0); cyc_chk("idle_again");

    run = 1'b1;
    play_start("pat_kept");
    for (int c = 1; c < 6; c++) play_cyc("pre_shrink");
    step_len = 16'd3;
    play_cyc("len_shrink");

    rst = 1'b1;
    push(0, 0, 0); cyc_chk("rst_mid");
    for (int i = 0; i < NS; i++) pat[i] = '0;
    rst = 1'b0;
    play_start("pat_cleared");
    run = 1'b0;
    push(0, 0, 0); cyc_chk("final_idle");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
